// File: rtl/jk_bank_sequencer.sv
// Arbitrates JK bank commands from two requesters, applies j/k for one cycle,
// waits SETTLE cycles, then verifies q_fb against the expected bank value.
module jk_bank_sequencer #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [1:0]       op0,
  input  logic [WIDTH-1:0] mask0,
  input  logic             req1,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] mask1,
  input  logic [WIDTH-1:0] q_fb,
  input  logic             err_clr,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             clr_n,
  output logic             busy,
  output logic             done0,
  output logic             done1,
  output logic             err
);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_CHECK
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'((SETTLE > 0) ? SETTLE - 1 : 0);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             last_grant_q, last_grant_d;
  logic             gid_q, gid_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic             done0_q, done0_d;
  logic             done1_q, done1_d;
  logic             err_q, err_d;

  logic             grant_id;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_mask;
  logic [WIDTH-1:0] op_val;

  always_comb begin
    // On a tie the requester that did not win last time is served.
    grant_id = (req0 && req1) ? ~last_grant_q : req1;
    sel_op   = grant_id ? op1 : op0;
    sel_mask = grant_id ? mask1 : mask0;
    op_val   = q_fb;
    case (sel_op)
      2'b00:   op_val = q_fb;
      2'b01:   op_val = '0;
      2'b10:   op_val = '1;
      default: op_val = ~q_fb;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    gid_d        = gid_q;
    exp_d        = exp_q;
    j_d          = '0;
    k_d          = '0;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    err_d        = err_q & ~err_clr;

    case (state_q)
      S_CLEAR: begin
        if (cnt_q == 4'd1) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_IDLE: begin
        if (req0 || req1) begin
          gid_d        = grant_id;
          last_grant_d = grant_id;
          exp_d        = (q_fb & ~sel_mask) | (op_val & sel_mask);
          j_d          = sel_mask & {WIDTH{sel_op[1]}};
          k_d          = sel_mask & {WIDTH{sel_op[0]}};
          state_d      = S_APPLY;
        end
      end
      S_APPLY: begin
        cnt_d = '0;
        if (SETTLE == 0) begin
          state_d = S_CHECK;
          done0_d = ~gid_q;
          done1_d = gid_q;
        end else begin
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = S_CHECK;
          done0_d = ~gid_q;
          done1_d = gid_q;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_CHECK: begin
        // A mismatch this cycle wins over a simultaneous err_clr.
        if (q_fb != exp_q) err_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_CLEAR;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      gid_q        <= 1'b0;
      exp_q        <= '0;
      j_q          <= '0;
      k_q          <= '0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      gid_q        <= gid_d;
      exp_q        <= exp_d;
      j_q          <= j_d;
      k_q          <= k_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      err_q        <= err_d;
    end
  end

  assign j     = j_q;
  assign k     = k_q;
  assign clr_n = (state_q != S_CLEAR);
  assign busy  = (state_q != S_IDLE);
  assign done0 = done0_q;
  assign done1 = done1_q;
  assign err   = err_q;

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Bench for jk_bank_sequencer: a JK bank model closes the q_fb loop; directed
// vectors, hand-written corner sequences and a randomized run against a reference model.
module tb_jk_bank_sequencer;

  logic       clk = 1'b0;
  logic       rst, req0, req1, err_clr;
  logic [1:0] op0, op1;
  logic [3:0] mask0, mask1, q_fb, j, k;
  logic       clr_n, busy, done0, done1, err;

  logic [3:0] bank_q = 4'b0;
  logic [3:0] stuck  = 4'b0;

  int n_cmp = 0;
  int n_bad = 0;

  jk_bank_sequencer #(.WIDTH(4), .SETTLE(2)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .mask0(mask0),
    .req1(req1), .op1(op1), .mask1(mask1),
    .q_fb(q_fb), .err_clr(err_clr),
    .j(j), .k(k), .clr_n(clr_n), .busy(busy),
    .done0(done0), .done1(done1), .err(err)
  );

  always #5 clk = ~clk;

  // Behavioural JK bank; bits listed in stuck read back as 0.
  always @(posedge clk) begin
    if (!clr_n) bank_q <= 4'b0;
    else begin
      for (int i = 0; i < 4; i++) begin
        case ({j[i], k[i]})
          2'b01:   bank_q[i] <= 1'b0;
          2'b10:   bank_q[i] <= ~stuck[i];
          2'b11:   bank_q[i] <= ~bank_q[i] & ~stuck[i];
          default: bank_q[i] <= bank_q[i] & ~stuck[i];
        endcase
      end
    end
  end
  assign q_fb = bank_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model: bank value after one command, bit by bit.
  function automatic logic [3:0] model_next(input logic [3:0] q, input logic [1:0] op,
                                            input logic [3:0] m);
    logic [3:0] r;
    r = q;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        if (op == 2'b01)      r[i] = 1'b0;
        else if (op == 2'b10) r[i] = 1'b1;
        else if (op == 2'b11) r[i] = ~q[i];
      end
    end
    return r;
  endfunction

  task automatic run_cmd(input logic r0, input logic r1,
                         input logic [1:0] o0, input logic [1:0] o1,
                         input logic [3:0] m0, input logic [3:0] m1,
                         input logic exp_id, input logic [3:0] ej, input logic [3:0] ek,
                         input string tag);
    int cyc;
    bit got;
    req0 = r0; req1 = r1; op0 = o0; op1 = o1; mask0 = m0; mask1 = m1;
    cyc = 0;
    got = 0;
    while (!got && cyc < 12) begin
      tick();
      cyc++;
      if (cyc == 1) begin
        chk({tag, " apply j"}, 32'(j), 32'(ej));
        chk({tag, " apply k"}, 32'(k), 32'(ek));
      end
      if (done0 && done1) chk({tag, " done overlap"}, 32'(1), 32'(0));
      if (done0 || done1) begin
        got = 1;
        chk({tag, " latency"}, 32'(cyc), 32'(4));
        chk({tag, " done id"}, 32'(done1), 32'(exp_id));
      end
    end
    if (!got) chk({tag, " done timeout"}, 32'(0), 32'(1));
    req0 = 0; req1 = 0;
    tick();
  endtask

  typedef struct {
    logic       id;
    logic [1:0] op;
    logic [3:0] mask;
    logic [3:0] exp_j;
    logic [3:0] exp_k;
    logic [3:0] exp_q;
  } vec_t;

  initial begin
    vec_t       vecs[5];
    logic [3:0] model_q;
    logic       model_last;
    int         done_ids[$];
    int         done_cyc[$];
    bit         early;
    int         cyc;

    vecs[0] = '{1'b0, 2'b10, 4'b0101, 4'b0101, 4'b0000, 4'b0101};
    vecs[1] = '{1'b1, 2'b11, 4'b1111, 4'b1111, 4'b1111, 4'b1010};
    vecs[2] = '{1'b1, 2'b01, 4'b0010, 4'b0000, 4'b0010, 4'b1000};
    vecs[3] = '{1'b0, 2'b00, 4'b1111, 4'b0000, 4'b0000, 4'b1000};
    vecs[4] = '{1'b1, 2'b10, 4'b0000, 4'b0000, 4'b0000, 4'b1000};

    rst = 1; req0 = 0; req1 = 0; op0 = 0; op1 = 0; mask0 = 0; mask1 = 0; err_clr = 0;

    // Reset and clear window.
    for (int i = 0; i < 3; i++) tick();
    chk("rst clr_n", 32'(clr_n), 32'(0));
    chk("rst busy", 32'(busy), 32'(1));
    chk("rst jk", 32'({j, k}), 32'(0));
    chk("rst done/err", 32'({done0, done1, err}), 32'(0));
    rst = 0;
    req0 = 1; op0 = 2'b10; mask0 = 4'b1111;
    #1;
    chk("clear cycle 1 clr_n", 32'(clr_n), 32'(0));
    tick();
    chk("clear cycle 2 clr_n", 32'(clr_n), 32'(0));
    chk("clear ignores req", 32'({j, busy}), 32'({4'b0, 1'b1}));
    req0 = 0;
    tick();
    chk("idle clr_n", 32'(clr_n), 32'(1));
    chk("idle busy", 32'(busy), 32'(0));
    chk("bank cleared", 32'(q_fb), 32'(0));

    // Single-requester vectors.
    foreach (vecs[i]) begin
      run_cmd(~vecs[i].id, vecs[i].id, vecs[i].op, vecs[i].op, vecs[i].mask, vecs[i].mask,
              vecs[i].id, vecs[i].exp_j, vecs[i].exp_k, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d q", i), 32'(q_fb), 32'(vecs[i].exp_q));
      chk($sformatf("vec%0d err", i), 32'(err), 32'(0));
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'(0));
    end

    // Contention: both held, grants alternate starting with requester 0.
    req0 = 1; op0 = 2'b10; mask0 = 4'b0011;
    req1 = 1; op1 = 2'b11; mask1 = 4'b1100;
    for (int c = 1; c <= 19; c++) begin
      tick();
      if (done0 && done1) chk("contention overlap", 32'(1), 32'(0));
      if (done0 || done1) begin
        done_ids.push_back(int'(done1));
        done_cyc.push_back(c);
      end
    end
    req0 = 0; req1 = 0;
    tick();
    chk("contention count", 32'(done_ids.size()), 32'(4));
    for (int i = 0; i < done_ids.size() && i < 4; i++) begin
      chk($sformatf("contention id%0d", i), 32'(done_ids[i]), 32'(i % 2));
      chk($sformatf("contention cyc%0d", i), 32'(done_cyc[i]), 32'(4 + 5 * i));
    end
    chk("contention q", 32'(q_fb), 32'(4'b1011));

    // Readback fault, sticky err, err_clr.
    stuck = 4'b0100;
    run_cmd(1, 0, 2'b10, 2'b00, 4'b0100, 4'b0000, 0, 4'b0100, 4'b0000, "fault");
    chk("fault err", 32'(err), 32'(1));
    chk("fault q", 32'(q_fb), 32'(4'b1011));
    stuck = 4'b0000;
    run_cmd(0, 1, 2'b00, 2'b11, 4'b0000, 4'b0001, 1, 4'b0001, 4'b0001, "post fault");
    chk("err sticky", 32'(err), 32'(1));
    chk("post fault q", 32'(q_fb), 32'(4'b1010));
    err_clr = 1;
    tick();
    err_clr = 0;
    chk("err cleared", 32'(err), 32'(0));

    // Reset during SETTLE abandons the command; held req is re-granted.
    req0 = 1; op0 = 2'b10; mask0 = 4'b0101;
    tick();
    tick();
    rst = 1;
    tick();
    chk("midrst clr_n", 32'(clr_n), 32'(0));
    chk("midrst jk", 32'({j, k}), 32'(0));
    chk("midrst done/err", 32'({done0, done1, err}), 32'(0));
    rst = 0;
    cyc = 0;
    early = 0;
    while (!(done0 || done1) && cyc < 15) begin
      tick();
      cyc++;
    end
    chk("midrst redo done0", 32'({done0, done1}), 32'(2'b10));
    chk("midrst redo latency", 32'(cyc), 32'(6));
    req0 = 0;
    tick();
    chk("midrst redo q", 32'(q_fb), 32'(4'b0101));
    chk("midrst redo err", 32'(err), 32'(0));

    // Randomized commands against the reference model.
    model_q = 4'b0101;
    model_last = 1'b0;
    for (int it = 0; it < 40; it++) begin
      int         pat;
      logic [1:0] o0r, o1r, wop;
      logic [3:0] m0r, m1r, wm, wj, wk;
      logic       win;
      pat = $urandom_range(1, 3);
      o0r = 2'($urandom); o1r = 2'($urandom);
      m0r = 4'($urandom); m1r = 4'($urandom);
      if (pat == 3) win = ~model_last;
      else win = (pat == 2);
      wop = win ? o1r : o0r;
      wm  = win ? m1r : m0r;
      wj  = (wop == 2'b10 || wop == 2'b11) ? wm : 4'b0;
      wk  = (wop == 2'b01 || wop == 2'b11) ? wm : 4'b0;
      run_cmd(pat[0], pat[1], o0r, o1r, m0r, m1r, win, wj, wk, $sformatf("rnd%0d", it));
      model_q    = model_next(model_q, wop, wm);
      model_last = win;
      chk($sformatf("rnd%0d q", it), 32'(q_fb), 32'(model_q));
      chk($sformatf("rnd%0d err", it), 32'(err), 32'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
